// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bundle for the boot loader.
// master = byte source / observer side, slave = the loader.
interface imem_loader_if;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic        rx_ready;
   logic        imem_we;
   logic [31:0] imem_waddr;
   logic [31:0] imem_wdata;
   logic        cpu_reset;
   logic        done;
   logic        err;

   modport master (
      output rx_valid, rx_byte,
      input  rx_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, done, err
   );

   modport slave (
      input  rx_valid, rx_byte,
      output rx_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, done, err
   );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: takes a length-prefixed little-endian byte stream, writes it into
// instruction memory word by word, then releases the CPU from reset.
//
// state | meaning
// HDR0  | waiting for word count low byte
// HDR1  | waiting for word count high byte, range-check N
// LOAD  | assembling the next 32-bit word from 4 bytes
// WRITE | single-cycle imem write strobe
// DONE  | program loaded, CPU released (terminal)
// ERR   | header rejected, CPU held (terminal)
module imem_loader #(
   parameter int          MAX_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   imem_loader_if.slave bus
);

   typedef enum logic [2:0] {HDR0, HDR1, LOAD, WRITE, DONE, ERR} state_t;

   state_t      state;
   logic [15:0] n;
   logic [15:0] k;
   logic [1:0]  byte_cnt;
   logic [31:0] asm_word;

   logic        xfer;
   logic [15:0] n_hdr;
   logic [31:0] word_next;

   assign xfer      = bus.rx_valid & bus.rx_ready;
   assign n_hdr     = {bus.rx_byte, n[7:0]};
   // first byte received ends up in [7:0] after four shifts
   assign word_next = {bus.rx_byte, asm_word[31:8]};

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= HDR0;
         n              <= '0;
         k              <= '0;
         byte_cnt       <= '0;
         asm_word       <= '0;
         bus.rx_ready   <= 1'b1;
         bus.imem_we    <= 1'b0;
         bus.imem_waddr <= BASE_ADDR;
         bus.imem_wdata <= '0;
         bus.cpu_reset  <= 1'b1;
         bus.done       <= 1'b0;
         bus.err        <= 1'b0;
      end else begin
         case (state)
            HDR0: begin
               if (xfer) begin
                  n[7:0] <= bus.rx_byte;
                  state  <= HDR1;
               end
            end
            HDR1: begin
               if (xfer) begin
                  n <= n_hdr;
                  if (n_hdr != 16'd0 && 32'(n_hdr) <= 32'(MAX_WORDS)) begin
                     state <= LOAD;
                  end else begin
                     state        <= ERR;
                     bus.rx_ready <= 1'b0;
                     bus.err      <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (xfer) begin
                  asm_word <= word_next;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     state          <= WRITE;
                     bus.rx_ready   <= 1'b0;
                     bus.imem_we    <= 1'b1;
                     bus.imem_wdata <= word_next;
                     bus.imem_waddr <= BASE_ADDR + {14'd0, k, 2'b00};
                  end
               end
            end
            WRITE: begin
               bus.imem_we <= 1'b0;
               k           <= k + 16'd1;
               if (k + 16'd1 == n) begin
                  state         <= DONE;
                  bus.cpu_reset <= 1'b0;
                  bus.done      <= 1'b1;
               end else begin
                  state        <= LOAD;
                  bus.rx_ready <= 1'b1;
               end
            end
            DONE, ERR: ;
            default: state <= HDR0;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a default instance and a small
// MAX_WORDS=4 / BASE_ADDR=0x100 instance share one byte driver.
module tb_imem_loader;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       valid = 1'b0;
   logic       sel = 1'b0;
   logic [7:0] byte_d = 8'h00;
   logic       rdy;

   int checks = 0;
   int failures = 0;

   logic [63:0] exp_a[$];
   logic [63:0] exp_b[$];

   imem_loader_if ifa();
   imem_loader_if ifb();

   imem_loader dut_a (.clk(clk), .reset(reset), .bus(ifa));
   imem_loader #(.MAX_WORDS(4), .BASE_ADDR(32'h100)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

   assign ifa.rx_valid = valid & ~sel;
   assign ifb.rx_valid = valid & sel;
   assign ifa.rx_byte  = byte_d;
   assign ifb.rx_byte  = byte_d;
   assign rdy = sel ? ifb.rx_ready : ifa.rx_ready;

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // monitors: every write strobe must match the next queued expectation
   always @(negedge clk) begin
      if (ifa.imem_we === 1'b1) begin
         if (exp_a.size() == 0) begin
            checks++; failures++;
            $display("FAIL a_unexpected_write actual=%h@%h required=none", ifa.imem_wdata, ifa.imem_waddr);
         end else begin
            logic [63:0] e;
            e = exp_a.pop_front();
            chk("a_waddr", ifa.imem_waddr, e[63:32]);
            chk("a_wdata", ifa.imem_wdata, e[31:0]);
            chk("a_rdy_in_write", {31'd0, ifa.rx_ready}, 32'd0);
            chk("a_cpurst_in_write", {31'd0, ifa.cpu_reset}, 32'd1);
         end
      end
   end

   always @(negedge clk) begin
      if (ifb.imem_we === 1'b1) begin
         if (exp_b.size() == 0) begin
            checks++; failures++;
            $display("FAIL b_unexpected_write actual=%h@%h required=none", ifb.imem_wdata, ifb.imem_waddr);
         end else begin
            logic [63:0] e;
            e = exp_b.pop_front();
            chk("b_waddr", ifb.imem_waddr, e[63:32]);
            chk("b_wdata", ifb.imem_wdata, e[31:0]);
            chk("b_rdy_in_write", {31'd0, ifb.rx_ready}, 32'd0);
         end
      end
   end

   task automatic do_reset();
      valid  = 1'b1;
      byte_d = 8'hAA;
      reset  = 1'b0;
      repeat (2) @(negedge clk);
      valid = 1'b0;
      reset = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      valid = 1'b0;
      repeat (gap) @(negedge clk);
      valid  = 1'b1;
      byte_d = b;
      t = 0;
      while (!rdy && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!rdy) begin
         checks++; failures++;
         $display("FAIL send_timeout actual=rx_ready_low required=rx_ready_high byte=%h", b);
      end
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic send_seq(input logic [7:0] s[$], input int maxgap);
      foreach (s[i]) send_byte(s[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      // reset state
      sel = 1'b0;
      do_reset();
      chk("rst_rdy",    {31'd0, ifa.rx_ready},  32'd1);
      chk("rst_we",     {31'd0, ifa.imem_we},   32'd0);
      chk("rst_waddr",  ifa.imem_waddr,         32'h0);
      chk("rst_wdata",  ifa.imem_wdata,         32'h0);
      chk("rst_cpurst", {31'd0, ifa.cpu_reset}, 32'd1);
      chk("rst_done",   {31'd0, ifa.done},      32'd0);
      chk("rst_err",    {31'd0, ifa.err},       32'd0);
      chk("rst_b_waddr", ifb.imem_waddr,        32'h100);

      // two-word program, valid held high
      exp_a.push_back({32'h0, 32'h0000_0013});
      exp_a.push_back({32'h4, 32'h0000_006F});
      send_seq('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00}, 0);
      chk("two_we_last", {31'd0, ifa.imem_we}, 32'd1);
      @(negedge clk);
      chk("two_done",   {31'd0, ifa.done},      32'd1);
      chk("two_cpurst", {31'd0, ifa.cpu_reset}, 32'd0);
      chk("two_rdy",    {31'd0, ifa.rx_ready},  32'd0);
      valid = 1'b1;
      repeat (5) @(negedge clk);
      valid = 1'b0;
      chk("two_done_hold", {31'd0, ifa.done}, 32'd1);

      // zero-length header
      do_reset();
      send_seq('{8'h00, 8'h00}, 0);
      chk("zero_err",    {31'd0, ifa.err},       32'd1);
      chk("zero_cpurst", {31'd0, ifa.cpu_reset}, 32'd1);
      chk("zero_rdy",    {31'd0, ifa.rx_ready},  32'd0);
      valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         byte_d = 8'(i);
         @(negedge clk);
      end
      valid = 1'b0;
      chk("zero_err_hold",  {31'd0, ifa.err},      32'd1);
      chk("zero_done_hold", {31'd0, ifa.done},     32'd0);
      chk("zero_rdy_hold",  {31'd0, ifa.rx_ready}, 32'd0);

      // small instance: too long, then exactly MAX_WORDS
      sel = 1'b1;
      do_reset();
      send_seq('{8'h05, 8'h00}, 0);
      chk("max_over_err", {31'd0, ifb.err}, 32'd1);
      do_reset();
      send_seq('{8'h04, 8'h00}, 0);
      chk("max_eq_err", {31'd0, ifb.err},      32'd0);
      chk("max_eq_rdy", {31'd0, ifb.rx_ready}, 32'd1);
      exp_b.push_back({32'h100, 32'h1122_3344});
      exp_b.push_back({32'h104, 32'hA5A5_A5A5});
      exp_b.push_back({32'h108, 32'h0000_0001});
      exp_b.push_back({32'h10C, 32'hFFFF_FFFF});
      send_seq('{8'h44, 8'h33, 8'h22, 8'h11, 8'hA5, 8'hA5, 8'hA5, 8'hA5,
                 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 0);
      @(negedge clk);
      chk("max_eq_done", {31'd0, ifb.done}, 32'd1);

      // one word at base 0x100
      do_reset();
      exp_b.push_back({32'h100, 32'hDEAD_BEEF});
      send_seq('{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 0);
      @(negedge clk);
      chk("base_done", {31'd0, ifb.done}, 32'd1);

      // one word with random idle gaps
      sel = 1'b0;
      do_reset();
      exp_a.push_back({32'h0, 32'h0000_05B3});
      send_seq('{8'h01, 8'h00, 8'hB3, 8'h05, 8'h00, 8'h00}, 7);
      @(negedge clk);
      chk("gap_done", {31'd0, ifa.done}, 32'd1);

      // abort mid-word, then full reload
      do_reset();
      exp_a.push_back({32'h0, 32'h0050_0113});
      send_seq('{8'h03, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h37, 8'h12}, 0);
      do_reset();
      chk("abort_rdy",   {31'd0, ifa.rx_ready}, 32'd1);
      chk("abort_we",    {31'd0, ifa.imem_we},  32'd0);
      chk("abort_waddr", ifa.imem_waddr,        32'h0);
      exp_a.push_back({32'h0, 32'h0010_0093});
      exp_a.push_back({32'h4, 32'h0020_8113});
      exp_a.push_back({32'h8, 32'h0000_006F});
      send_seq('{8'h03, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h81, 8'h20, 8'h00,
                 8'h6F, 8'h00, 8'h00, 8'h00}, 0);
      @(negedge clk);
      chk("reload_done",   {31'd0, ifa.done},      32'd1);
      chk("reload_cpurst", {31'd0, ifa.cpu_reset}, 32'd0);

      repeat (3) @(negedge clk);
      chk("a_queue_left", exp_a.size(), 32'd0);
      chk("b_queue_left", exp_b.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
